// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    // addi x0,x0,0
    localparam logic [INST_W-1:0] NOP_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with its next-pc selection (redirect, +4, hold).
import if_pkg::*;

module if_pc_reg #(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;

    // A redirect always beats sequential advance.
    always_comb begin
        pc_next = pc_reg;
        if (load) begin
            pc_next = target;
        end else if (incr) begin
            pc_next = pc_reg + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, registers the IMEM word toward decode with valid/ready.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
import if_pkg::*;

module if_fetch_unit #(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                MEM_NBYTE = 4096,
    parameter logic [INST_W-1:0] NOP_INST  = NOP_ENC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(MEM_NBYTE - 4);

    state_t            state_reg, state_next;
    logic              out_valid_reg, out_valid_next;
    logic [INST_W-1:0] out_inst_reg, out_inst_next;
    logic [ADDR_W-1:0] out_pc_reg, out_pc_next;
    logic              fault_reg, fault_next;
    logic [31:0]       fetch_count_reg;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] load_target;
    logic              pc_load;
    logic              pc_incr;
    logic              adv;
    logic              run_fetch;
    logic              misaligned;

    assign adv       = !out_valid_reg || out_ready;
    assign run_fetch = (state_reg == S_RUN) && fetch_en && adv;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned  = redirect_target[1:0] != 2'b00;
    assign load_target = redirect_target;
`else
    assign misaligned  = 1'b0;
    assign load_target = {redirect_target[ADDR_W-1:2], 2'b00};
`endif

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .target (load_target),
        .incr   (pc_incr),
        .pc     (pc)
    );

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_inst_next  = out_inst_reg;
        out_pc_next    = out_pc_reg;
        fault_next     = fault_reg;
        pc_load        = 1'b0;
        pc_incr        = 1'b0;

        if (state_reg == S_BOOT) begin
            state_next = S_RUN;
        end

        if (redirect_valid) begin
            // Whatever sits in the output register is dropped, accepted or not.
            pc_load        = 1'b1;
            out_valid_next = 1'b0;
            out_inst_next  = NOP_INST;
            if (misaligned) begin
                state_next = S_HALT;
                fault_next = 1'b1;
            end else begin
                state_next = S_RUN;
                fault_next = 1'b0;
            end
        end else if (run_fetch && (pc > PC_LAST)) begin
            state_next     = S_HALT;
            fault_next     = 1'b1;
            out_valid_next = 1'b0;
        end else if (run_fetch) begin
            out_inst_next  = imem_inst;
            out_pc_next    = pc;
            out_valid_next = 1'b1;
            pc_incr        = 1'b1;
        end else if (adv) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_BOOT;
            out_valid_reg   <= 1'b0;
            out_inst_reg    <= NOP_INST;
            out_pc_reg      <= '0;
            fault_reg       <= 1'b0;
            fetch_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_inst_reg  <= out_inst_next;
            out_pc_reg    <= out_pc_next;
            fault_reg     <= fault_next;
            if (out_valid_reg && out_ready && !redirect_valid) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
        end
    end

    assign imem_addr   = pc;
    assign out_valid   = out_valid_reg;
    assign out_inst    = out_inst_reg;
    assign out_pc      = out_pc_reg;
    assign fault       = fault_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a default-size instance plus a 16-byte IMEM instance.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        out_ready = 1'b0;

    logic [31:0] imem_addr, imem_inst, out_inst, out_pc, fetch_count;
    logic        out_valid, fault;
    logic [31:0] s_imem_addr, s_imem_inst, s_out_inst, s_out_pc, s_fetch_count;
    logic        s_out_valid, s_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0000_0093;
        if (addr == 32'h4) return 32'h0050_0113;
        return 32'h1000_0000 | addr;
    endfunction

    assign imem_inst   = imem_word(imem_addr);
    assign s_imem_inst = imem_word(s_imem_addr);

    if_fetch_unit u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_inst       (imem_inst),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    if_fetch_unit #(.MEM_NBYTE(16)) u_small (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (s_imem_addr),
        .imem_inst       (s_imem_inst),
        .out_valid       (s_out_valid),
        .out_ready       (out_ready),
        .out_inst        (s_out_inst),
        .out_pc          (s_out_pc),
        .fault           (s_fault),
        .fetch_count     (s_fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end else begin
            $display("ok   %s value=%h", tag, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset values
        #1 rst_n = 1'b0;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", out_inst, 32'h0000_0013);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        tick(1);
        rst_n = 1'b1;

        // boot idle cycle, then streaming
        tick(1);
        chk("boot_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("f0_valid", 32'(out_valid), 32'd1);
        chk("f0_pc", out_pc, 32'h0);
        chk("f0_inst", out_inst, 32'h0000_0093);
        chk("f0_count", fetch_count, 32'd0);
        tick(1);
        chk("f1_pc", out_pc, 32'h4);
        chk("f1_inst", out_inst, 32'h0050_0113);
        chk("f1_count", fetch_count, 32'd1);
        tick(1);
        chk("f2_pc", out_pc, 32'h8);
        chk("f2_count", fetch_count, 32'd2);

        // three stalled cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall_pc", out_pc, 32'h8);
            chk("stall_inst", out_inst, 32'h1000_0008);
            chk("stall_addr", imem_addr, 32'hC);
            chk("stall_count", fetch_count, 32'd2);
        end
        out_ready = 1'b1;
        tick(1);
        chk("resume_pc", out_pc, 32'hC);
        chk("resume_count", fetch_count, 32'd3);

        // redirect while decode stalls
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'hC;
        tick(1);
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        chk("rd_valid", 32'(out_valid), 32'd0);
        chk("rd_addr", imem_addr, 32'hC);
        chk("rd_inst", out_inst, 32'h0000_0013);
        tick(1);
        chk("rd_pc", out_pc, 32'hC);
        chk("rd_count", fetch_count, 32'd3);
        tick(1);
        chk("rd_next_count", fetch_count, 32'd4);

        // redirect with out_ready=1 discards the held word uncounted
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        tick(1);
        redirect_valid = 1'b0;
        chk("rd2_count", fetch_count, 32'd4);
        chk("rd2_addr", imem_addr, 32'h20);

        // asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_fault", 32'(fault), 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        fetch_en = 1'b0;
        tick(1);
        rst_n = 1'b1;

        // fetch_en low: nothing issued after boot
        tick(2);
        chk("noen_valid", 32'(out_valid), 32'd0);
        chk("noen_addr", imem_addr, 32'd0);
        fetch_en = 1'b1;

        // 16-byte IMEM: 0,4,8,12 then fault
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("small_pc", s_out_pc, 32'(i * 4));
            chk("small_valid", 32'(s_out_valid), 32'd1);
        end
        tick(1);
        chk("small_fault", 32'(s_fault), 32'd1);
        chk("small_fvalid", 32'(s_out_valid), 32'd0);
        chk("small_faddr", s_imem_addr, 32'd16);
        tick(1);
        chk("small_hold_addr", s_imem_addr, 32'd16);
        chk("small_hold_fault", 32'(s_fault), 32'd1);
        redirect_valid = 1'b1;
        redirect_target = 32'h0;
        tick(1);
        redirect_valid = 1'b0;
        chk("small_clr_fault", 32'(s_fault), 32'd0);
        chk("small_clr_addr", s_imem_addr, 32'd0);
        tick(1);
        chk("small_resume_valid", 32'(s_out_valid), 32'd1);
        chk("small_resume_pc", s_out_pc, 32'd0);

        // last legal word of the default 4 KiB range
        redirect_valid = 1'b1;
        redirect_target = 32'hFFC;
        tick(1);
        redirect_valid = 1'b0;
        chk("edge_addr", imem_addr, 32'hFFC);
        tick(1);
        chk("edge_pc", out_pc, 32'hFFC);
        chk("edge_inst", out_inst, 32'h1000_0FFC);
        tick(1);
        chk("edge_fault", 32'(fault), 32'd1);
        chk("edge_valid", 32'(out_valid), 32'd0);
        chk("edge_addr_hold", imem_addr, 32'h1000);

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_target = 32'h6;
        tick(1);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_addr", imem_addr, 32'h6);
        chk("mis_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("mis_halt_valid", 32'(out_valid), 32'd0);
        chk("mis_halt_fault", 32'(fault), 32'd1);
`else
        chk("mis_fault", 32'(fault), 32'd0);
        chk("mis_addr", imem_addr, 32'h4);
        chk("mis_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("mis_run_valid", 32'(out_valid), 32'd1);
        chk("mis_run_pc", out_pc, 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
